// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM for the shared-memory multi-cycle MIPS
//               datapath. Sequences FETCH, DECODE, EXECUTE, MEMORY and
//               WRITEBACK. Stalls on the memory ready handshake and pulses
//               illegal_op on undefined opcodes.
// Options     : define MCTRL_JUMP_EN to decode OP_J into the JUMP state;
//               without it OP_J is treated as an illegal opcode.
// Ports       : clk, rst_n (async, active low)
//               opcode     - IR[31:26], sampled only in DECODE
//               mem_ready  - memory completes the current access this cycle
//               mem_read, mem_write, i_or_d, ir_write, pc_write,
//               pc_write_cond, pc_source, alu_op, alu_src_a, alu_src_b,
//               reg_dst, reg_write, mem_to_reg - datapath controls
//               illegal_op - one-cycle pulse on an undefined opcode
//               instr_done - one-cycle pulse when an instruction retires
//               state      - current state code (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int                  OPCODE_W = 6,
  parameter logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000,
  parameter logic [OPCODE_W-1:0] OP_LW    = 6'b100011,
  parameter logic [OPCODE_W-1:0] OP_SW    = 6'b101011,
  parameter logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100,
  parameter logic [OPCODE_W-1:0] OP_J     = 6'b000010
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic [1:0]          alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                illegal_op,
  output logic                instr_done,
  output logic [3:0]          state
);

`ifdef MCTRL_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_LW    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
  } state_t;

  state_t              r_state;
  logic [OPCODE_W-1:0] r_opcode;   // opcode captured in DECODE

  // Live opcode classification, only meaningful while in DECODE.
  logic w_is_mem;
  logic w_is_r;
  logic w_is_beq;
  logic w_jump_hit;
  logic w_legal;

  assign w_is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
  assign w_is_r     = (opcode == OP_RTYPE);
  assign w_is_beq   = (opcode == OP_BEQ);
  // Without the jump option OP_J falls through to the illegal path.
  assign w_jump_hit = JUMP_EN && (opcode == OP_J);
  assign w_legal    = w_is_mem || w_is_r || w_is_beq || w_jump_hit;

  assign state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_opcode <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_opcode <= opcode;
          if (w_is_mem) begin
            r_state <= S_MEM_ADDR;
          end else if (w_is_r) begin
            r_state <= S_EXEC_R;
          end else if (w_is_beq) begin
            r_state <= S_BRANCH;
          end else if (w_jump_hit) begin
            r_state <= S_JUMP;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM_ADDR: begin
          // Only lw/sw reach here, so the latched copy picks the access type.
          r_state <= (r_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          if (mem_ready) r_state <= S_WB_LW;
        end
        S_MEM_WR: begin
          if (mem_ready) r_state <= S_FETCH;
        end
        S_EXEC_R: r_state <= S_WB_R;
        S_WB_LW,
        S_WB_R,
        S_BRANCH,
        S_JUMP:   r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the registered state. The only input-dependent terms
  // are the mem_ready qualifiers on the memory handshake states and the
  // illegal opcode flag in DECODE.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;        // PC + 4
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;       // branch target precompute
        illegal_op = !w_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        // Unreachable without the jump option; stays silent there so
        // pc_source can never present the jump target.
        if (JUMP_EN) begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Each instruction
//               is expanded by a reference model into the per-cycle control
//               word and handshake pattern, then compared cycle by cycle.
//               Honours MCTRL_JUMP_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ILL = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic       alu_src_a, reg_dst, reg_write, mem_to_reg, illegal_op, instr_done;
  logic [3:0] state;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw, iod, irw, pcw, pcwc;
    logic [1:0] pcs, aop;
    logic       asa;
    logic [1:0] asb;
    logic       rd, rw, m2r, ill, done;
  } ctl_t;

  typedef struct {
    bit         rdy;
    logic [5:0] op;
    ctl_t       exp;
  } step_t;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic ctl_t observed();
    ctl_t c;
    c = {state, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
         pc_source, alu_op, alu_src_a, alu_src_b, reg_dst, reg_write,
         mem_to_reg, illegal_op, instr_done};
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Instruction class as the opcode table defines it.
  function automatic int classify(input logic [5:0] op);
    case (op)
      OP_RTYPE: return K_R;
      OP_LW:    return K_LW;
      OP_SW:    return K_SW;
      OP_BEQ:   return K_BEQ;
`ifdef MCTRL_JUMP_EN
      OP_J:     return K_J;
`endif
      default:  return K_ILL;
    endcase
  endfunction

  // Cycles from FETCH to retire with zero-wait memory (illegal: FETCH+DECODE).
  function automatic int base_latency(input int kind);
    case (kind)
      K_R:     return 4;
      K_LW:    return 5;
      K_SW:    return 4;
      K_BEQ:   return 3;
      K_J:     return 3;
      default: return 2;
    endcase
  endfunction

  function automatic ctl_t fetch_ctl(input bit go);
    ctl_t c = '0;
    c.st = 4'd0; c.mr = 1'b1; c.asb = 2'b01; c.irw = go; c.pcw = go;
    return c;
  endfunction

  // Expand one instruction into expected cycles, drive it, and compare.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string tag);
    step_t q[$];
    step_t s;
    ctl_t  c;
    int    kind, nf, nm, lat, dones, ills, exp_lat;
    bit    seen;
    kind = classify(op);
    nf = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
    nm = (mw < 0) ? int'($urandom_range(0, 3)) : mw;

    for (int i = 0; i <= nf; i++) begin
      s.rdy = (i == nf); s.op = 6'($urandom); s.exp = fetch_ctl(s.rdy);
      q.push_back(s);
    end
    c = '0; c.st = 4'd1; c.asb = 2'b11; c.ill = (kind == K_ILL);
    s.rdy = 1'($urandom); s.op = op; s.exp = c;
    q.push_back(s);
    case (kind)
      K_LW, K_SW: begin
        c = '0; c.st = 4'd2; c.asa = 1'b1; c.asb = 2'b10;
        s.rdy = 1'($urandom); s.op = 6'($urandom); s.exp = c;
        q.push_back(s);
        for (int i = 0; i <= nm; i++) begin
          c = '0; c.iod = 1'b1; s.rdy = (i == nm); s.op = 6'($urandom);
          if (kind == K_LW) begin
            c.st = 4'd3; c.mr = 1'b1;
          end else begin
            c.st = 4'd5; c.mw = 1'b1; c.done = s.rdy;
          end
          s.exp = c;
          q.push_back(s);
        end
        if (kind == K_LW) begin
          c = '0; c.st = 4'd4; c.rw = 1'b1; c.m2r = 1'b1; c.done = 1'b1;
          s.rdy = 1'($urandom); s.op = 6'($urandom); s.exp = c;
          q.push_back(s);
        end
      end
      K_R: begin
        c = '0; c.st = 4'd6; c.asa = 1'b1; c.aop = 2'b10;
        s.rdy = 1'($urandom); s.op = 6'($urandom); s.exp = c;
        q.push_back(s);
        c = '0; c.st = 4'd7; c.rw = 1'b1; c.rd = 1'b1; c.done = 1'b1;
        s.exp = c;
        q.push_back(s);
      end
      K_BEQ: begin
        c = '0; c.st = 4'd8; c.asa = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1;
        c.pcs = 2'b01; c.done = 1'b1;
        s.rdy = 1'($urandom); s.op = 6'($urandom); s.exp = c;
        q.push_back(s);
      end
      K_J: begin
        c = '0; c.st = 4'd9; c.pcw = 1'b1; c.pcs = 2'b10; c.done = 1'b1;
        s.rdy = 1'($urandom); s.op = 6'($urandom); s.exp = c;
        q.push_back(s);
      end
      default: ;
    endcase

    exp_lat = base_latency(kind) + nf + (((kind == K_LW) || (kind == K_SW)) ? nm : 0);
    lat = 0; dones = 0; ills = 0; seen = 1'b0;
    foreach (q[i]) begin
      @(negedge clk);
      mem_ready = q[i].rdy;
      opcode    = q[i].op;
      #1;
      chk($sformatf("%s cyc%0d ctl", tag, i), 32'(observed()), 32'(q[i].exp));
      if (!seen) lat++;
      if (instr_done) dones++;
      if (illegal_op) ills++;
      if (instr_done || illegal_op) seen = 1'b1;
    end
    chk($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s done_pulses", tag), 32'(dones), (kind == K_ILL) ? 32'd0 : 32'd1);
    chk($sformatf("%s illegal_pulses", tag), 32'(ills), (kind == K_ILL) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [5:0] op;
    int         kind;

    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
    #1;
    chk("reset ctl", 32'(observed()), 32'(fetch_ctl(1'b0)));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_instr(OP_RTYPE, 0, 0, "rtype");
    run_instr(OP_LW,    0, 3, "lw_wait3");
    run_instr(OP_SW,    0, 0, "sw");
    run_instr(OP_BEQ,   0, 0, "beq");
    run_instr(6'h3F,    0, 0, "illegal");
    run_instr(OP_J,     0, 0, "jump");
    run_instr(OP_SW,    2, 2, "sw_waits");

    // Random mix with random handshake stalls.
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        K_R:   op = OP_RTYPE;
        K_LW:  op = OP_LW;
        K_SW:  op = OP_SW;
        K_BEQ: op = OP_BEQ;
        K_J:   op = OP_J;
        default: begin
          do op = 6'($urandom); while (classify(op) != K_ILL);
        end
      endcase
      run_instr(op, -1, -1, $sformatf("rnd%0d_op%02h", n, op));
    end

    // Reset while a store is stalled in MEM_WR.
    @(negedge clk); mem_ready = 1'b1; opcode = 6'($urandom);
    @(negedge clk); mem_ready = 1'b0; opcode = OP_SW;
    @(negedge clk); opcode = 6'd0;
    @(negedge clk); mem_ready = 1'b0;
    #1;
    chk("rst_mid_wr state_before", 32'(state), 32'd5);
    chk("rst_mid_wr mem_write_before", 32'(mem_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_wr state_async", 32'(state), 32'd0);
    chk("rst_mid_wr mem_write_async", 32'(mem_write), 32'd0);
    chk("rst_mid_wr ctl_async", 32'(observed()), 32'(fetch_ctl(1'b0)));
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    chk("rst_release ir_write", 32'(ir_write), 32'd1);
    chk("rst_release ctl", 32'(observed()), 32'(fetch_ctl(1'b1)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
